// File: rtl/decode_queue_if.sv
// Bundles the fetch-side and execute-side handshakes of the buffered decode stage.
// The master modport is the surrounding pipeline (fetch and execute), and the
// slave modport is the decode queue itself.
interface decode_queue_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [5:0]      out_op;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [4:0]      out_rd;
   logic [XLEN-1:0] out_imm;
   logic            out_use_imm;
   logic [XLEN-1:0] out_pc;
   logic            out_illegal;
   logic [CW-1:0]   count;

   modport master (
      output flush, in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_op, out_rs1, out_rs2, out_rd,
             out_imm, out_use_imm, out_pc, out_illegal, count
   );

   modport slave (
      input  flush, in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_op, out_rs1, out_rs2, out_rd,
             out_imm, out_use_imm, out_pc, out_illegal, count
   );
endinterface

// File: rtl/decode_queue.sv
// Buffered RV32I decode stage. Fetched instructions and their PCs are held in a
// DEPTH-entry FIFO; the head entry is decoded combinationally and offered to
// execute. Ready is derived from the registered occupancy, so a full queue
// never accepts in the same cycle that it drains.
module decode_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input logic           clk,
   input logic           rst_n,
   decode_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   logic [31:0]     instrMem [DEPTH];
   logic [XLEN-1:0] pcMem    [DEPTH];

   logic [PW-1:0] rdPtr_q, rdPtr_d;
   logic [PW-1:0] wrPtr_q, wrPtr_d;
   logic [CW-1:0] count_q, count_d;

   logic doPush;
   logic doPop;

   logic [31:0] headInstr;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] iImm, sImm, bImm, jImm, uImm;
   logic [5:0]  op;
   logic        useImm;
   logic        illegal;
   logic [31:0] imm32;

   assign bus.in_ready  = (count_q != CW'(DEPTH));
   assign bus.out_valid = (count_q != '0);
   assign bus.count     = count_q;

   assign doPush = bus.in_valid & bus.in_ready;
   assign doPop  = bus.out_valid & bus.out_ready;

   // Next pointer/occupancy values; flush wins over any push or pop in the same cycle.
   always_comb begin
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      count_d = count_q;
      if (bus.flush) begin
         rdPtr_d = '0;
         wrPtr_d = '0;
         count_d = '0;
      end else begin
         if (doPush) wrPtr_d = wrPtr_q + PW'(1);
         if (doPop)  rdPtr_d = rdPtr_q + PW'(1);
         case ({doPush, doPop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers; reset empties the queue without touching storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else begin
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
         count_q <= count_d;
      end
   end

   // Entry storage is written on an accepted push; contents are never reset.
   always_ff @(posedge clk) begin
      if (doPush && !bus.flush) begin
         instrMem[wrPtr_q] <= bus.in_instr;
         pcMem[wrPtr_q]    <= bus.in_pc;
      end
   end

   assign headInstr = instrMem[rdPtr_q];
   assign opcode    = headInstr[6:0];
   assign funct3    = headInstr[14:12];
   assign funct7    = headInstr[31:25];

   assign iImm = {{20{headInstr[31]}}, headInstr[31:20]};
   assign sImm = {{20{headInstr[31]}}, headInstr[31:25], headInstr[11:7]};
   assign bImm = {{20{headInstr[31]}}, headInstr[7], headInstr[30:25], headInstr[11:8], 1'b0};
   assign jImm = {{12{headInstr[31]}}, headInstr[19:12], headInstr[20], headInstr[30:21], 1'b0};
   assign uImm = {headInstr[31:12], 12'b0};

   // Decode of the head entry into op class, immediate select and the illegal flag.
   always_comb begin
      op      = '0;
      useImm  = 1'b0;
      illegal = 1'b0;
      imm32   = '0;
      case (opcode)
         OPC_OP: begin
            if (funct7 == 7'b0000000 ||
                (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))
               op = {1'b1, funct7[5], 1'b1, funct3};
            else
               illegal = 1'b1;
         end
         OPC_OPIMM: begin
            useImm = 1'b1;
            if (funct3[1:0] == 2'b01) begin
               op    = {1'b0, funct7[5], 1'b1, funct3};
               imm32 = {27'b0, headInstr[24:20]};
            end else begin
               op    = {1'b0, 1'b0, 1'b1, funct3};
               imm32 = iImm;
            end
         end
         OPC_LOAD: begin
            if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
               illegal = 1'b1;
            end else begin
               op     = {1'b0, 1'b1, 1'b0, funct3};
               useImm = 1'b1;
               imm32  = iImm;
            end
         end
         OPC_STORE: begin
            if (funct3 >= 3'b011) begin
               illegal = 1'b1;
            end else begin
               op     = {1'b1, 1'b1, 1'b0, funct3};
               useImm = 1'b1;
               imm32  = sImm;
            end
         end
         OPC_BRANCH: begin
            if (funct3 == 3'b010 || funct3 == 3'b011) begin
               illegal = 1'b1;
            end else begin
               op    = {1'b1, 1'b0, 1'b0, funct3};
               imm32 = bImm;
            end
         end
         OPC_JALR: begin
            op     = {3'b000, opcode[5:3]};
            useImm = 1'b1;
            imm32  = iImm;
         end
         OPC_JAL: begin
            op    = {3'b000, opcode[5:3]};
            imm32 = jImm;
         end
         OPC_AUIPC, OPC_LUI: begin
            op    = {3'b000, opcode[5:3]};
            imm32 = uImm;
         end
         default: illegal = 1'b1;
      endcase
      if (headInstr == 32'h0) begin
         op      = '0;
         useImm  = 1'b0;
         illegal = 1'b0;
         imm32   = '0;
      end
   end

   assign bus.out_op      = op;
   assign bus.out_use_imm = useImm;
   assign bus.out_illegal = illegal;
   assign bus.out_imm     = XLEN'($signed(imm32));
   assign bus.out_rs1     = headInstr[19:15];
   assign bus.out_rs2     = headInstr[24:20];
   assign bus.out_rd      = headInstr[11:7];
   assign bus.out_pc      = pcMem[rdPtr_q];
endmodule
